// File: rtl/change_dispenser.sv
// Coin change dispenser: greedy payout from four stocked denominations through a hopper handshake.
// Optional OFFER timeout is compiled in with `define CHANGE_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for start; stock loads accepted
// SELECT | pick largest affordable in-stock coin, or finish
// OFFER  | coin_valid held until hopper acks
// DONE   | one-cycle done pulse, then back to IDLE
module change_dispenser (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [10:0] amount,
   input  logic        load,
   input  logic [1:0]  load_code,
   input  logic [7:0]  load_count,
   output logic        coin_valid,
   output logic [1:0]  coin_code,
   input  logic        coin_ack,
   output logic        busy,
   output logic        done,
   output logic        short,
   output logic [10:0] remaining
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SELECT,
      S_OFFER,
      S_DONE
   } state_t;

   localparam logic [1:0] CODE_10  = 2'd0;
   localparam logic [1:0] CODE_20  = 2'd1;
   localparam logic [1:0] CODE_100 = 2'd2;
   localparam logic [1:0] CODE_50  = 2'd3;

   state_t      state;
   logic [7:0]  stock [4];
   logic        sel_found;
   logic [1:0]  sel_code;

`ifdef CHANGE_TIMEOUT_EN
   logic [7:0]  offer_timer;
`endif

   function automatic logic [10:0] coin_value(input logic [1:0] code);
      case (code)
         CODE_10:  coin_value = 11'd10;
         CODE_20:  coin_value = 11'd20;
         CODE_100: coin_value = 11'd100;
         default:  coin_value = 11'd50;
      endcase
   endfunction

   // Largest denomination first; a remainder of zero naturally selects nothing.
   always_comb begin
      sel_found = 1'b0;
      sel_code  = CODE_10;
      if (remaining >= 11'd100 && stock[CODE_100] != 8'd0) begin
         sel_found = 1'b1;
         sel_code  = CODE_100;
      end else if (remaining >= 11'd50 && stock[CODE_50] != 8'd0) begin
         sel_found = 1'b1;
         sel_code  = CODE_50;
      end else if (remaining >= 11'd20 && stock[CODE_20] != 8'd0) begin
         sel_found = 1'b1;
         sel_code  = CODE_20;
      end else if (remaining >= 11'd10 && stock[CODE_10] != 8'd0) begin
         sel_found = 1'b1;
         sel_code  = CODE_10;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         coin_valid <= 1'b0;
         coin_code  <= 2'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         short      <= 1'b0;
         remaining  <= 11'd0;
         for (int i = 0; i < 4; i++) stock[i] <= 8'd0;
`ifdef CHANGE_TIMEOUT_EN
         offer_timer <= 8'd0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               // A load in the same cycle as start lands before the first SELECT.
               if (load) stock[load_code] <= load_count;
               if (start) begin
                  remaining <= amount;
                  short     <= 1'b0;
                  busy      <= 1'b1;
                  state     <= S_SELECT;
               end
            end
            S_SELECT: begin
               if (sel_found) begin
                  coin_valid <= 1'b1;
                  coin_code  <= sel_code;
                  state      <= S_OFFER;
`ifdef CHANGE_TIMEOUT_EN
                  offer_timer <= 8'd254;
`endif
               end else begin
                  short <= (remaining != 11'd0);
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_OFFER: begin
               if (coin_ack) begin
                  remaining         <= remaining - coin_value(coin_code);
                  stock[coin_code]  <= stock[coin_code] - 8'd1;
                  coin_valid        <= 1'b0;
                  state             <= S_SELECT;
               end
`ifdef CHANGE_TIMEOUT_EN
               // Terminal count reached after 255 unacknowledged OFFER cycles:
               // treat this denomination as jammed and continue with the others.
               else if (offer_timer == 8'd0) begin
                  stock[coin_code] <= 8'd0;
                  coin_valid       <= 1'b0;
                  state            <= S_SELECT;
               end else begin
                  offer_timer <= offer_timer - 8'd1;
               end
`endif
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
